// File: rtl/cache_write_buffer.sv
// Posted write buffer: circular FIFO between cache write-back and memory, with
// same-word coalescing and combinational read forwarding for refills.
module cache_write_buffer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_hit_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StDrain, StDone} flush_state_e;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q;
    flush_state_e          state_q, state_d;

    logic                  pop;
    logic                  push_append;
    logic                  push_drop;
    logic                  wr_match;
    logic [PTR_W-1:0]      wr_idx;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign overflow_o  = overflow_q;
    assign mem_req_o   = !empty_o;
    assign mem_addr_o  = addr_q[head_q];
    assign mem_wdata_o = data_q[head_q];
    assign pop         = mem_req_o && mem_ready_i;

    // A head that leaves this edge cannot absorb the write; it must be re-queued.
    always_comb begin
        wr_match = 1'b0;
        wr_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_WIDTH-1:2] == wr_addr_i[ADDR_WIDTH-1:2]) &&
                !(pop && (PTR_W'(i) == head_q))) begin
                wr_match = 1'b1;
                wr_idx   = PTR_W'(i);
            end
        end
    end

    assign push_append = wr_en_i && !wr_match && (!full_o || pop);
    assign push_drop   = wr_en_i && !wr_match && full_o && !pop;
    assign count_d     = count_q + CNT_W'(push_append) - CNT_W'(pop);

    // When full with a pop, tail == head: the append must win over the pop clear.
    always_comb begin
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
        end
        if (push_append) begin
            valid_d[tail_q] = 1'b1;
        end
    end

    always_comb begin
        rd_hit_o  = 1'b0;
        rd_data_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_WIDTH-1:2] == rd_addr_i[ADDR_WIDTH-1:2])) begin
                rd_hit_o  = 1'b1;
                rd_data_o = data_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_done_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    state_d = (count_d == '0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                if (count_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                flush_done_o = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= StIdle;
        end else begin
            head_q  <= head_q + PTR_W'(pop);
            tail_q  <= tail_q + PTR_W'(push_append);
            count_q <= count_d;
            valid_q <= valid_d;
            state_q <= state_d;
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i && wr_match) begin
            data_q[wr_idx] <= wr_data_i;
        end else if (push_append) begin
            addr_q[tail_q] <= wr_addr_i;
            data_q[tail_q] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Bench for cache_write_buffer: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_cache_write_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic        flush, flush_done, full, empty, overflow;
    logic        mem_req, mem_ready;
    logic [31:0] mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];       // model contents, head first
    ent_t exp_mem[$];  // writes memory should have received
    ent_t obs_mem[$];  // writes memory did receive
    bit   m_ovf, m_flushing, m_done;

    always #5 clk = ~clk;

    cache_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_addr_i   (rd_addr),
        .rd_hit_o    (rd_hit),
        .rd_data_o   (rd_data),
        .flush_i     (flush),
        .flush_done_o(flush_done),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (overflow),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ready_i (mem_ready)
    );

    always @(posedge clk) begin
        if (!rst && mem_req && mem_ready) obs_mem.push_back('{mem_addr, mem_wdata});
    end

    function automatic void model_clear();
        mq.delete();
        exp_mem.delete();
        obs_mem.delete();
        m_ovf = 0;
        m_flushing = 0;
        m_done = 0;
    endfunction

    function automatic void model_rd(input logic [31:0] a, output bit hit, output logic [31:0] d);
        hit = 0;
        d = '0;
        foreach (mq[i]) if (mq[i].a[31:2] == a[31:2]) begin hit = 1; d = mq[i].d; end
    endfunction

    // One clock edge worth of behaviour, applied to the model from the current inputs.
    function automatic void model_update();
        bit pop = (mq.size() > 0) && mem_ready;
        bit start = flush && !m_flushing && !m_done;
        int idx = -1;
        if (pop) exp_mem.push_back(mq[0]);
        if (wr_en) for (int i = (pop ? 1 : 0); i < mq.size(); i++)
            if (mq[i].a[31:2] == wr_addr[31:2]) idx = i;
        if (wr_en && idx >= 0) mq[idx].d = wr_data;
        if (pop) void'(mq.pop_front());
        if (wr_en && idx < 0) begin
            if (mq.size() < DEPTH) mq.push_back('{wr_addr, wr_data});
            else m_ovf = 1;
        end
        if ((m_flushing || start) && mq.size() == 0) begin
            m_done = 1;
            m_flushing = 0;
        end else begin
            m_done = 0;
            if (start) m_flushing = 1;
        end
    endfunction

    task automatic drive(input bit we, input logic [31:0] wa, input logic [31:0] wd,
                         input bit rdy, input bit fl);
        wr_en = we;
        wr_addr = wa;
        wr_data = wd;
        mem_ready = rdy;
        flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic push(input logic [31:0] wa, input logic [31:0] wd);
        drive(1, wa, wd, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rd_addr = 0;
        rst = 1;
        #1;
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
    endtask

    task automatic test_reset();
        drive(1, 32'h40, 32'h1, 1, 1);
        rst = 1;
        #2;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", full); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", mem_req); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", flush_done); end
        rd_addr = 32'h40;
        #1;
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b want=0", rd_hit); end
        do_reset();
    endtask

    task automatic test_fill_and_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(4 * i), 32'hA000 + 32'(i));
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b want=1", full); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL fill_head got=%h want=100", mem_addr); end
        tick();
        tick();
        checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hA000) begin
            errors++; $display("FAIL fill_stable got=%h/%h want=100/a000", mem_addr, mem_wdata);
        end
        push(32'h200, 32'hDEAD);
        rd_addr = 32'h200;
        #1;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", overflow); end
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL ovf_dropped got=%b want=0", rd_hit); end
        checks++; if (mem_addr !== 32'h100 || full !== 1'b1) begin
            errors++; $display("FAIL ovf_contents got=%h full=%b want=100 full=1", mem_addr, full);
        end
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) tick();
        #1;
        checks++; if (overflow !== 1'b1 || empty !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got=%b empty=%b want=1 1", overflow, empty);
        end
    endtask

    task automatic test_coalesce();
        do_reset();
        push(32'h104, 32'hD1);
        push(32'h104, 32'hD2);
        rd_addr = 32'h104;
        #1;
        checks++; if (rd_hit !== 1'b1 || rd_data !== 32'hD2) begin
            errors++; $display("FAIL coalesce_fwd got=%b/%h want=1/d2", rd_hit, rd_data);
        end
        drive(0, 0, 0, 1, 0);
        tick();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL coalesce_single got empty=%b want=1", empty); end
        checks++; if (obs_mem.size() != 1 || obs_mem[0].a !== 32'h104 || obs_mem[0].d !== 32'hD2) begin
            errors++; $display("FAIL coalesce_mem got n=%0d want one write 104=d2", obs_mem.size());
        end
    endtask

    task automatic test_full_pop_push();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(4 * i), 32'hB000 + 32'(i));
        drive(1, 32'h300, 32'hC300, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        rd_addr = 32'h300;
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullpp_count got full=%b want=1", full); end
        checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL fullpp_head got=%h want=104", mem_addr); end
        checks++; if (rd_hit !== 1'b1 || rd_data !== 32'hC300) begin
            errors++; $display("FAIL fullpp_tail got=%b/%h want=1/c300", rd_hit, rd_data);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got=%b want=0", overflow); end
    endtask

    task automatic test_head_collide();
        do_reset();
        push(32'h100, 32'hD0);
        drive(1, 32'h100, 32'hD3, 1, 0);
        rd_addr = 32'h100;
        #1;
        checks++; if (rd_data !== 32'hD0) begin errors++; $display("FAIL collide_fwd got=%h want=d0", rd_data); end
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        checks++; if (obs_mem.size() != 1 || obs_mem[0].d !== 32'hD0) begin
            errors++; $display("FAIL collide_old got n=%0d want one write of d0", obs_mem.size());
        end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hD3) begin
            errors++; $display("FAIL collide_new got=%b %h/%h want=1 100/d3", mem_req, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_flush();
        int pulses = 0;
        int pulse_cyc = -1;
        do_reset();
        for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), 32'hE0 + 32'(i));
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, 0, (c % 2) == 0, c == 0);
            #1;
            checks++; if (flush_done !== m_done) begin
                errors++; $display("FAIL flush_pulse c=%0d got=%b want=%b", c, flush_done, m_done);
            end
            if (flush_done === 1'b1) begin pulses++; pulse_cyc = c; end
            tick();
        end
        checks++; if (pulses != 1 || pulse_cyc != 5) begin
            errors++; $display("FAIL flush_once got pulses=%0d at=%0d want 1 at 5", pulses, pulse_cyc);
        end
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b want=1", flush_done); end
        tick();
        #1;
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_empty_end got=%b want=0", flush_done); end
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i), 32'hF0 + 32'(i));
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        rst = 1;
        #1;
        checks++; if (empty !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_rst got empty=%b req=%b want 1 0", empty, mem_req);
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
        tick();
        #1;
        checks++; if (flush_done !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL flush_rst_after got done=%b empty=%b want 0 1", flush_done, empty);
        end
    endtask

    task automatic test_random();
        bit          hit_e;
        logic [31:0] d_e;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 6, 32'h100 + 32'(4 * $urandom_range(0, 11)) + 32'($urandom_range(0, 3)),
                  $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            rd_addr = 32'h100 + 32'(4 * $urandom_range(0, 11));
            #1;
            model_rd(rd_addr, hit_e, d_e);
            checks++; if (mem_req !== (mq.size() > 0)) begin
                errors++; $display("FAIL rnd_req c=%0d got=%b want=%b", c, mem_req, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                checks++; if (mem_addr !== mq[0].a || mem_wdata !== mq[0].d) begin
                    errors++; $display("FAIL rnd_head c=%0d got=%h/%h want=%h/%h", c, mem_addr, mem_wdata, mq[0].a, mq[0].d);
                end
            end
            checks++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
                errors++; $display("FAIL rnd_level c=%0d got full=%b empty=%b want n=%0d", c, full, empty, mq.size());
            end
            checks++; if (overflow !== m_ovf) begin
                errors++; $display("FAIL rnd_ovf c=%0d got=%b want=%b", c, overflow, m_ovf);
            end
            checks++; if (rd_hit !== hit_e || rd_data !== d_e) begin
                errors++; $display("FAIL rnd_fwd c=%0d got=%b/%h want=%b/%h", c, rd_hit, rd_data, hit_e, d_e);
            end
            checks++; if (flush_done !== m_done) begin
                errors++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, flush_done, m_done);
            end
            tick();
        end
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 1; i++) tick();
        checks++; if (obs_mem.size() != exp_mem.size()) begin
            errors++; $display("FAIL rnd_mem_count got=%0d want=%0d", obs_mem.size(), exp_mem.size());
        end else begin
            foreach (exp_mem[i]) begin
                checks++; if (obs_mem[i].a !== exp_mem[i].a || obs_mem[i].d !== exp_mem[i].d) begin
                    errors++; $display("FAIL rnd_mem i=%0d got=%h/%h want=%h/%h", i, obs_mem[i].a,
                                       obs_mem[i].d, exp_mem[i].a, exp_mem[i].d);
                end
            end
        end
    endtask

    initial begin
        rst = 1;
        drive(0, 0, 0, 0, 0);
        rd_addr = 0;
        #3;
        test_reset();
        test_fill_and_overflow();
        test_coalesce();
        test_full_pop_push();
        test_head_collide();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
